// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the tick-driven counter bank: per-channel mode
//   encodings, the bounce direction type and the load-value clamp helper.
//   No ports; imported by tick_counter_bank.
package counter_pkg;

  localparam logic [1:0] MODE_UP_WRAP = 2'b00;
  localparam logic [1:0] MODE_DN_WRAP = 2'b01;
  localparam logic [1:0] MODE_UP_SAT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE  = 2'b11;

  // Direction bit of a channel; only BOUNCE changes it, but every mode keeps it
  // so that re-entering BOUNCE continues in the remembered direction.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Saturate a requested value at the top count.
  function automatic logic [31:0] clamp_max(input logic [31:0] value,
                                            input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Single-clock prescaler producing a one-cycle tick enable every DIV cycles
//   while run is high. No derived clocks.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   run   in  count enable; the prescaler holds its value while low
//   clr   in  synchronous restart from 0, suppresses tick
//   tick  out high for the cycle in which the prescaler sits at DIV-1 with run=1
module tick_prescaler #(
  parameter int DIV = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] phase;

  // tick is combinational from the phase so it lines up with the cycle in
  // which the counters sample it.
  assign tick = run & ~clr & (phase == LAST);

  // Phase register: restarts on clr, freezes while run is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (run) begin
      phase <= (phase == LAST) ? '0 : phase + CW'(1);
    end
  end

endmodule

// File: rtl/tick_counter_bank.sv
// tick_counter_bank
//   Bank of CHANNELS independent WIDTH-bit counters advanced by a shared
//   prescaler tick, each in its own mode (up-wrap, down-wrap, up-saturate,
//   bounce), with a valid/ready load port backed by one shared load buffer.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   run       in  prescaler enable
//   clr       in  synchronous clear of prescaler, counters, directions, pending load
//   ch_en     in  per-channel tick enable
//   ch_mode   in  per-channel mode, bits [2i+1:2i] for channel i
//   ld_valid  in  load request
//   ld_ready  out load can be accepted
//   ld_ch     in  target channel of the load
//   ld_value  in  value to load (clamped to MAX)
//   tick      out one-cycle prescaler pulse
//   count     out counter values, channel i at [WIDTH*i +: WIDTH]
//   wrap      out per-channel one-cycle wrap/reversal/saturation pulse
module tick_counter_bank #(
  parameter int DIV       = 20000000,
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 5,
  parameter int MAX       = 31,
  parameter int LOAD_SYNC = 1,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [2*CHANNELS-1:0]     ch_mode,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [CH_W-1:0]           ld_ch,
  input  logic [WIDTH-1:0]          ld_value,
  output logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       wrap
);

  import counter_pkg::*;

  localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH:0]   ONE_X  = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);

  logic             ready_q;
  logic             ld_accept;
  logic [WIDTH-1:0] ld_clamped;
  logic             apply_en;
  logic [CH_W-1:0]  apply_ch;
  logic [WIDTH-1:0] apply_val;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (clr),
    .tick  (tick)
  );

  assign ld_accept  = ld_valid & ld_ready;
  assign ld_clamped = WIDTH'(clamp_max(32'(ld_value), 32'(MAX)));

  // Out of reset the port stays not-ready until the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  if (LOAD_SYNC != 0) begin : g_sync_load
    logic             pend_valid;
    logic [CH_W-1:0]  pend_ch;
    logic [WIDTH-1:0] pend_val;

    // One shared buffer: an accepted load waits here for the next tick, and
    // the port refuses further loads until it has been consumed. Loads aimed
    // at a channel that does not exist are buffered and simply match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_valid <= 1'b0;
        pend_ch    <= '0;
        pend_val   <= '0;
      end else if (clr) begin
        pend_valid <= 1'b0;
      end else if (ld_accept) begin
        pend_valid <= 1'b1;
        pend_ch    <= ld_ch;
        pend_val   <= ld_clamped;
      end else if (tick) begin
        pend_valid <= 1'b0;
      end
    end

    assign ld_ready  = ready_q & ~pend_valid & ~clr;
    assign apply_en  = pend_valid & tick;
    assign apply_ch  = pend_ch;
    assign apply_val = pend_val;
  end else begin : g_direct_load
    assign ld_ready  = ready_q & ~clr;
    assign apply_en  = ld_accept;
    assign apply_ch  = ld_ch;
    assign apply_val = ld_clamped;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] value_q;
    logic             wrap_q;
    dir_e             dir_q;
    logic [WIDTH:0]   cur;
    logic [WIDTH:0]   nxt;
    logic             nxt_wrap;
    dir_e             nxt_dir;
    logic [1:0]       mode;
    logic             hit_load;

    assign mode     = ch_mode[2*i +: 2];
    assign hit_load = apply_en && (apply_ch == CH_W'(i));

    // Next value for a tick, computed one bit wider than the counter so the
    // step past MAX (or below 0) is visible before it is compared.
    always_comb begin
      cur      = {1'b0, value_q};
      nxt      = cur;
      nxt_wrap = 1'b0;
      nxt_dir  = dir_q;
      case (mode)
        MODE_UP_WRAP: begin
          if (cur >= MAX_X) begin
            nxt      = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt = cur + ONE_X;
          end
        end
        MODE_DN_WRAP: begin
          if (cur == '0) begin
            nxt      = MAX_X;
            nxt_wrap = 1'b1;
          end else begin
            nxt = cur - ONE_X;
          end
        end
        MODE_UP_SAT: begin
          if (cur >= MAX_X) begin
            nxt = MAX_X;
          end else begin
            nxt      = cur + ONE_X;
            nxt_wrap = (nxt == MAX_X);
          end
        end
        MODE_BOUNCE: begin
          // Direction flips on the step that reaches an end; a channel that
          // enters BOUNCE already sitting at an end turns around first.
          if (dir_q == DIR_UP) begin
            if (cur >= MAX_X) begin
              nxt      = MAX_X - ONE_X;
              nxt_dir  = DIR_DOWN;
              nxt_wrap = (nxt == '0);
            end else begin
              nxt = cur + ONE_X;
              if (nxt == MAX_X) begin
                nxt_wrap = 1'b1;
                nxt_dir  = DIR_DOWN;
              end
            end
          end else begin
            if (cur == '0) begin
              nxt      = ONE_X;
              nxt_dir  = DIR_UP;
              nxt_wrap = (nxt == MAX_X);
            end else begin
              nxt = cur - ONE_X;
              if (nxt == '0) begin
                nxt_wrap = 1'b1;
                nxt_dir  = DIR_UP;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // Channel state: clr beats load, load beats the tick step (and reports
    // no wrap), otherwise wrap is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_q <= '0;
        wrap_q  <= 1'b0;
        dir_q   <= DIR_UP;
      end else if (clr) begin
        value_q <= '0;
        wrap_q  <= 1'b0;
        dir_q   <= DIR_UP;
      end else if (hit_load) begin
        value_q <= apply_val;
        wrap_q  <= 1'b0;
      end else if (tick && ch_en[i]) begin
        value_q <= nxt[WIDTH] ? MAX_W : nxt[WIDTH-1:0];
        wrap_q  <= nxt_wrap;
        dir_q   <= nxt_dir;
      end else begin
        wrap_q  <= 1'b0;
      end
    end

    assign count[WIDTH*i +: WIDTH] = value_q;
    assign wrap[i]                 = wrap_q;
  end

endmodule

// File: tb/tb_tick_counter_bank.sv
// tb_tick_counter_bank
//   Directed bench for tick_counter_bank. Three instances share the input
//   stimulus, all with DIV=4 and two channels:
//     dut_a: LOAD_SYNC=1, WIDTH=4, MAX=7 (buffered loads, clamp, clr, reset)
//     dut_b: LOAD_SYNC=0, WIDTH=3, MAX=7 (up-wrap sequence, immediate loads)
//     dut_c: LOAD_SYNC=1, WIDTH=3, MAX=3 (bounce sequence, run freeze)
module tb_tick_counter_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run, clr, ld_valid;
  logic [1:0] ch_en;
  logic [3:0] ch_mode;
  logic [0:0] ld_ch;
  logic [3:0] ld_value;

  logic       ld_ready_a, tick_a;
  logic [7:0] count_a;
  logic [1:0] wrap_a;
  logic       ld_ready_b, tick_b;
  logic [5:0] count_b;
  logic [1:0] wrap_b;
  logic       ld_ready_c, tick_c;
  logic [5:0] count_c;
  logic [1:0] wrap_c;

  int vec_count = 0;
  int err_count = 0;

  int bounce_seq [7] = '{1, 2, 3, 2, 1, 0, 1};
  int bounce_wrap[7] = '{0, 0, 1, 0, 0, 1, 0};

  always #5 clk = ~clk;

  tick_counter_bank #(.DIV(4), .CHANNELS(2), .WIDTH(4), .MAX(7), .LOAD_SYNC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .ch_en(ch_en), .ch_mode(ch_mode),
    .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_ch(ld_ch), .ld_value(ld_value),
    .tick(tick_a), .count(count_a), .wrap(wrap_a)
  );

  tick_counter_bank #(.DIV(4), .CHANNELS(2), .WIDTH(3), .MAX(7), .LOAD_SYNC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .ch_en(ch_en), .ch_mode(ch_mode),
    .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_ch(ld_ch), .ld_value(ld_value[2:0]),
    .tick(tick_b), .count(count_b), .wrap(wrap_b)
  );

  tick_counter_bank #(.DIV(4), .CHANNELS(2), .WIDTH(3), .MAX(3), .LOAD_SYNC(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .ch_en(ch_en), .ch_mode(ch_mode),
    .ld_valid(ld_valid), .ld_ready(ld_ready_c), .ld_ch(ld_ch), .ld_value(ld_value[2:0]),
    .tick(tick_c), .count(count_c), .wrap(wrap_c)
  );

  // Drive every shared input at once.
  task automatic applyStimulus(input logic r, input logic c, input logic [1:0] en,
                               input logic [3:0] mode, input logic v,
                               input logic ch, input logic [3:0] val);
    run      = r;
    clr      = c;
    ch_en    = en;
    ch_mode  = mode;
    ld_valid = v;
    ld_ch    = ch;
    ld_value = val;
  endtask

  // Count one comparison and report it if it miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset, check the reset state, release between edges and return one
  // time unit after the first edge out of reset.
  task automatic resetDuts();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_count_a", 32'(count_a), 0);
    checkOutput("rst_ready_a", 32'(ld_ready_a), 0);
    checkOutput("rst_wrap_b", 32'(wrap_b), 0);
    checkOutput("rst_tick_c", 32'(tick_c), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_ready_after_a", 32'(ld_ready_a), 1);
    checkOutput("rst_ready_after_b", 32'(ld_ready_b), 1);
  endtask

  initial begin
    $display("[TB] tick_counter_bank directed test start");

    // UP_WRAP on dut_b channel 0: one step every 4 cycles, wrap on 7->0.
    resetDuts();
    applyStimulus(1'b1, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 8; k++) begin
      waitEdges(3);
      checkOutput("t1_tick", 32'(tick_b), 1);
      waitEdges(1);
      checkOutput("t1_count", 32'(count_b[2:0]), k % 8);
      checkOutput("t1_wrap", 32'(wrap_b[0]), (k == 8) ? 1 : 0);
    end
    checkOutput("t1_tick_low", 32'(tick_b), 0);
    checkOutput("t1_ch1_idle", 32'(count_b[5:3]), 0);

    // BOUNCE on dut_c channel 0, with a run=0 freeze after the fourth step.
    resetDuts();
    applyStimulus(1'b1, 1'b0, 2'b01, 4'b0011, 1'b0, 1'b0, 4'd0);
    for (int j = 0; j < 7; j++) begin
      waitEdges(4);
      checkOutput("t2_count", 32'(count_c[2:0]), 32'(bounce_seq[j]));
      checkOutput("t2_wrap", 32'(wrap_c[0]), 32'(bounce_wrap[j]));
      if (j == 3) begin
        applyStimulus(1'b0, 1'b0, 2'b01, 4'b0011, 1'b0, 1'b0, 4'd0);
        for (int f = 0; f < 6; f++) begin
          waitEdges(1);
          checkOutput("t2_frozen_tick", 32'(tick_c), 0);
          checkOutput("t2_frozen_count", 32'(count_c[2:0]), 2);
        end
        applyStimulus(1'b1, 1'b0, 2'b01, 4'b0011, 1'b0, 1'b0, 4'd0);
      end
    end

    // Buffered load on dut_a: 9 clamps to 7, applied on the tick with no wrap.
    resetDuts();
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b1, 4'd9);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("t3_ready_low", 32'(ld_ready_a), 0);
    waitEdges(2);
    checkOutput("t3_tick", 32'(tick_a), 1);
    checkOutput("t3_count1_before", 32'(count_a[7:4]), 0);
    checkOutput("t3_ready_still_low", 32'(ld_ready_a), 0);
    waitEdges(1);
    checkOutput("t3_count1_loaded", 32'(count_a[7:4]), 7);
    checkOutput("t3_wrap1", 32'(wrap_a[1]), 0);
    checkOutput("t3_count0", 32'(count_a[3:0]), 1);
    checkOutput("t3_ready_back", 32'(ld_ready_a), 1);
    waitEdges(4);
    checkOutput("t3_count1_wrapped", 32'(count_a[7:4]), 0);
    checkOutput("t3_wrap1_pulse", 32'(wrap_a[1]), 1);
    checkOutput("t3_count0_next", 32'(count_a[3:0]), 2);

    // Immediate loads on dut_b: load wins on the tick cycle, also works off-tick.
    resetDuts();
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    waitEdges(3);
    checkOutput("t4_tick", 32'(tick_b), 1);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b0, 4'd5);
    #1;
    checkOutput("t4_ready", 32'(ld_ready_b), 1);
    waitEdges(1);
    checkOutput("t4_count0_load", 32'(count_b[2:0]), 5);
    checkOutput("t4_count1_step", 32'(count_b[5:3]), 1);
    checkOutput("t4_wrap0", 32'(wrap_b[0]), 0);
    checkOutput("t4_ready_stays", 32'(ld_ready_b), 1);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b1, 4'd3);
    waitEdges(1);
    checkOutput("t4_count1_offtick", 32'(count_b[5:3]), 3);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    waitEdges(2);
    checkOutput("t4_count0_after", 32'(count_b[2:0]), 6);
    checkOutput("t4_count1_after", 32'(count_b[5:3]), 4);

    // clr with a simultaneous load on dut_a: no accept, counts cleared, restart.
    resetDuts();
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    waitEdges(5);
    checkOutput("t5_count0_pre", 32'(count_a[3:0]), 1);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0000, 1'b1, 1'b0, 4'd3);
    #1;
    checkOutput("t5_ready_clr", 32'(ld_ready_a), 0);
    waitEdges(1);
    checkOutput("t5_counts_zero", 32'(count_a), 0);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    #1;
    checkOutput("t5_ready_after", 32'(ld_ready_a), 1);
    waitEdges(3);
    checkOutput("t5_tick_restart", 32'(tick_a), 1);
    checkOutput("t5_count0_hold", 32'(count_a[3:0]), 0);
    waitEdges(1);
    checkOutput("t5_count0_step", 32'(count_a[3:0]), 1);
    checkOutput("t5_count1_step", 32'(count_a[7:4]), 1);

    // Async reset on dut_a with a pending load: outputs clear at once, load lost.
    resetDuts();
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    waitEdges(4);
    checkOutput("t6_count0_pre", 32'(count_a[3:0]), 1);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b0, 4'd6);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("t6_pending", 32'(ld_ready_a), 0);
    waitEdges(1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_count", 32'(count_a), 0);
    checkOutput("t6_rst_wrap", 32'(wrap_a), 0);
    checkOutput("t6_rst_ready", 32'(ld_ready_a), 0);
    checkOutput("t6_rst_tick", 32'(tick_a), 0);
    #2;
    rst_n = 1'b1;
    waitEdges(1);
    checkOutput("t6_ready_back", 32'(ld_ready_a), 1);
    waitEdges(3);
    checkOutput("t6_count0_no_load", 32'(count_a[3:0]), 1);
    checkOutput("t6_count1", 32'(count_a[7:4]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
